// File: rtl/adc_pulse_gen.sv
// adc_pulse_gen: synthetic detector-pulse source for the shaping-filter chain.
// Each accepted trigger starts a linear rise to baseline+amplitude, followed by a
// shift-based exponential decay back to the baseline. Pile-up re-triggers from the
// current pulse value; triggers during the rise are counted as missed.
// Optional build macro ADC_PULSE_GEN_NOISE_EN adds LFSR noise to every sample.
module adc_pulse_gen #(
    parameter int SIZE_ADC_DATA = 14,
    parameter int PERIOD_W      = 16,
    parameter int RISE_SHIFT    = 2,
    parameter int DECAY_SHIFT   = 4,
    parameter int CNT_W         = 16,
    parameter int NOISE_BITS    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     trig_mode,
    input  logic                     ext_trig,
    input  logic [PERIOD_W-1:0]      period,
    input  logic [SIZE_ADC_DATA-2:0] amplitude,
    input  logic [SIZE_ADC_DATA-1:0] baseline,
    output logic [SIZE_ADC_DATA-1:0] adc_data,
    output logic                     pulse_start,
    output logic                     busy,
    output logic [CNT_W-1:0]         pulse_count,
    output logic [CNT_W-1:0]         missed_count
);

    localparam int P_W  = SIZE_ADC_DATA - 1;
    localparam int RC_W = RISE_SHIFT + 1;
`ifdef ADC_PULSE_GEN_NOISE_EN
    // one spare bit so full-scale baseline + pulse + noise cannot overflow
    localparam int SUM_W = SIZE_ADC_DATA + 2;
`else
    localparam int SUM_W = SIZE_ADC_DATA + 1;
`endif
    localparam logic [P_W-1:0]          PMAX      = {P_W{1'b1}};
    localparam logic [P_W-1:0]          DECAY_MIN = P_W'(2 ** DECAY_SHIFT);
    localparam logic [RC_W-1:0]         RISE_LAST = RC_W'(2 ** RISE_SHIFT - 1);
    localparam logic signed [SUM_W-1:0] ADC_MAX   = SUM_W'(2 ** (SIZE_ADC_DATA - 1) - 1);
    localparam logic signed [SUM_W-1:0] ADC_MIN   = SUM_W'(-(2 ** (SIZE_ADC_DATA - 1)));

    typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

    state_t                   state_q, state_d;
    logic [P_W-1:0]           p_q, p_d;
    logic [P_W-1:0]           tgt_q, tgt_d;
    logic [P_W-1:0]           step_q, step_d;
    logic [RC_W-1:0]          rcnt_q, rcnt_d;
    logic [PERIOD_W-1:0]      per_q, per_d;
    logic                     ext_trig_q;
    logic                     pulse_start_q, pulse_start_d;
    logic [CNT_W-1:0]         pcnt_q, pcnt_d;
    logic [CNT_W-1:0]         miss_q, miss_d;
    logic [SIZE_ADC_DATA-1:0] adc_q, adc_d;

    logic                     trg;
    logic [P_W:0]             sum_pa;
    logic [P_W-1:0]           tgt_new;
    logic [P_W-1:0]           step_new;
    logic signed [SUM_W-1:0]  sum;

`ifdef ADC_PULSE_GEN_NOISE_EN
    logic [15:0] lfsr_q;

    // free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
`endif

    // trigger detect, period counter next state, rise target/step and output clamp
    always_comb begin
        trg = enable & (trig_mode ? (ext_trig & ~ext_trig_q)
                                  : ((period != '0) && (per_q == period - PERIOD_W'(1))));
        per_d = '0;
        if (enable && !trig_mode && (period != '0))
            per_d = (per_q == period - PERIOD_W'(1)) ? '0 : per_q + PERIOD_W'(1);
        sum_pa   = {1'b0, p_q} + {1'b0, amplitude};
        tgt_new  = (sum_pa > {1'b0, PMAX}) ? PMAX : sum_pa[P_W-1:0];
        step_new = (tgt_new - p_q) >> RISE_SHIFT;
        sum = SUM_W'($signed(baseline)) + SUM_W'(p_q);
`ifdef ADC_PULSE_GEN_NOISE_EN
        sum = sum + SUM_W'($signed(lfsr_q[NOISE_BITS-1:0]));
`endif
        if (sum > ADC_MAX)      adc_d = ADC_MAX[SIZE_ADC_DATA-1:0];
        else if (sum < ADC_MIN) adc_d = ADC_MIN[SIZE_ADC_DATA-1:0];
        else                    adc_d = sum[SIZE_ADC_DATA-1:0];
    end

    // pulse FSM: next state, pulse value and event counters
    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        tgt_d         = tgt_q;
        step_d        = step_q;
        rcnt_d        = rcnt_q;
        pulse_start_d = 1'b0;
        pcnt_d        = pcnt_q;
        miss_d        = miss_q;
        case (state_q)
            IDLE, DECAY: begin
                if (trg) begin
                    // pile-up restarts the rise from the current value, p held this cycle
                    state_d       = RISE;
                    tgt_d         = tgt_new;
                    step_d        = step_new;
                    rcnt_d        = '0;
                    pulse_start_d = 1'b1;
                    pcnt_d        = pcnt_q + CNT_W'(1);
                end else if (state_q == DECAY) begin
                    if (p_q < DECAY_MIN) begin
                        p_d     = '0;
                        state_d = IDLE;
                    end else begin
                        p_d = p_q - (p_q >> DECAY_SHIFT);
                    end
                end
            end
            RISE: begin
                if (trg && (miss_q != '1)) miss_d = miss_q + CNT_W'(1);
                if (rcnt_q == RISE_LAST) begin
                    // last rise step lands exactly on the target, absorbing truncation
                    p_d     = tgt_q;
                    state_d = DECAY;
                end else begin
                    p_d    = p_q + step_q;
                    rcnt_d = rcnt_q + RC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            p_q           <= '0;
            tgt_q         <= '0;
            step_q        <= '0;
            rcnt_q        <= '0;
            per_q         <= '0;
            ext_trig_q    <= 1'b0;
            pulse_start_q <= 1'b0;
            pcnt_q        <= '0;
            miss_q        <= '0;
            adc_q         <= '0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            tgt_q         <= tgt_d;
            step_q        <= step_d;
            rcnt_q        <= rcnt_d;
            per_q         <= per_d;
            ext_trig_q    <= ext_trig;
            pulse_start_q <= pulse_start_d;
            pcnt_q        <= pcnt_d;
            miss_q        <= miss_d;
            adc_q         <= adc_d;
        end
    end

    assign adc_data     = adc_q;
    assign pulse_start  = pulse_start_q;
    assign busy         = (state_q != IDLE);
    assign pulse_count  = pcnt_q;
    assign missed_count = miss_q;

endmodule

// File: tb/tb_adc_pulse_gen.sv
// Directed bench for adc_pulse_gen (noise macro undefined, default parameters).
module tb_adc_pulse_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        trig_mode;
    logic        ext_trig;
    logic [15:0] period;
    logic [12:0] amplitude;
    logic [13:0] baseline;
    logic [13:0] adc_data;
    logic        pulse_start;
    logic        busy;
    logic [15:0] pulse_count;
    logic [15:0] missed_count;

    int n_chk = 0;
    int n_err = 0;

    adc_pulse_gen dut (
        .clk(clk), .reset(reset), .enable(enable), .trig_mode(trig_mode),
        .ext_trig(ext_trig), .period(period), .amplitude(amplitude),
        .baseline(baseline), .adc_data(adc_data), .pulse_start(pulse_start),
        .busy(busy), .pulse_count(pulse_count), .missed_count(missed_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled at the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        for (int i = 0; i < maxc && busy; i++) tick();
        chk(tag, busy, 0);
    endtask

    task automatic wait_strobe(input string tag, input int maxc);
        int i;
        for (i = 0; i < maxc && !pulse_start; i++) tick();
        chk(tag, pulse_start, 1);
    endtask

    int n, strobes;
    int exp_rise[5] = '{100, 350, 600, 850, 1100};

    initial begin
        reset = 1'b0; enable = 1'b1; trig_mode = 1'b1; ext_trig = 1'b0;
        period = 16'd0; amplitude = 13'd1000; baseline = 14'd100;
        repeat (2) @(negedge clk);
        chk("rst_adc", $signed(adc_data), 0);
        chk("rst_busy", busy, 0);
        chk("rst_pcnt", pulse_count, 0);
        chk("rst_miss", missed_count, 0);
        chk("rst_ps", pulse_start, 0);
        reset = 1'b1;
        tick();
        chk("first_adc", $signed(adc_data), 100);

        // single pulse: 100,350,600,850,1100 then decay 1038, 980
        ext_trig = 1'b1;
        tick();
        chk("sp_ps", pulse_start, 1);
        chk("sp_busy", busy, 1);
        chk("sp_pcnt", pulse_count, 1);
        ext_trig = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sp_rise", $signed(adc_data), exp_rise[i]);
        end
        tick(); chk("sp_dec1", $signed(adc_data), 1038);
        tick(); chk("sp_dec2", $signed(adc_data), 980);
        wait_idle("sp_idle", 300);
        tick(); chk("sp_base", $signed(adc_data), 100);

        // pile-up at p=938, then a rejected edge inside the new rise
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        repeat (5) tick();
        ext_trig = 1'b1;
        tick();
        chk("pu_pcnt", pulse_count, 3);
        chk("pu_ps", pulse_start, 1);
        chk("pu_adc0", $signed(adc_data), 1038);
        ext_trig = 1'b0;
        tick(); chk("pu_adc1", $signed(adc_data), 1038);
        ext_trig = 1'b1;
        tick(); chk("pu_adc2", $signed(adc_data), 1288);
        chk("rej_miss", missed_count, 1);
        chk("rej_ps", pulse_start, 0);
        ext_trig = 1'b0;
        tick(); chk("pu_adc3", $signed(adc_data), 1538);
        tick(); chk("pu_adc4", $signed(adc_data), 1788);
        tick(); chk("pu_adc5", $signed(adc_data), 2038);
        tick(); chk("pu_dec", $signed(adc_data), 1917);
        chk("pu_pcnt2", pulse_count, 3);
        wait_idle("pu_idle", 500);
        tick();

        // saturation high, then most negative baseline
        baseline = 14'd8000; amplitude = 13'h1FFF;
        tick(); chk("sat_base", $signed(adc_data), 8000);
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        tick(); chk("sat_lag", $signed(adc_data), 8000);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("sat_hi", $signed(adc_data), 8191);
        end
        baseline = 14'h2000;
        wait_idle("sat_idle", 500);
        tick(); chk("sat_lo", $signed(adc_data), -8192);

        // internal period triggers
        baseline = 14'd0; amplitude = 13'd50; period = 16'd100; trig_mode = 1'b0;
        wait_strobe("per_first", 300);
        n = 0;
        do begin tick(); n++; end while (!pulse_start && n < 300);
        chk("per_interval", n, 100);
        period = 16'd0;
        strobes = 0;
        for (int i = 0; i < 250; i++) begin tick(); strobes += pulse_start; end
        chk("per0_strobes", strobes, 0);
        chk("per0_busy", busy, 0);
        chk("per0_adc", $signed(adc_data), 0);
        period = 16'd100;
        wait_strobe("en_strobe", 300);
        enable = 1'b0;
        strobes = 0;
        for (int i = 0; i < 250; i++) begin tick(); strobes += pulse_start; end
        chk("en0_strobes", strobes, 0);
        chk("en0_busy", busy, 0);
        chk("en0_adc", $signed(adc_data), 0);

        // reset mid-decay clears everything at once
        enable = 1'b1; trig_mode = 1'b1; baseline = 14'd100; amplitude = 13'd1000;
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        repeat (8) tick();
        chk("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("ar_adc", $signed(adc_data), 0);
        chk("ar_busy", busy, 0);
        chk("ar_pcnt", pulse_count, 0);
        chk("ar_miss", missed_count, 0);
        chk("ar_ps", pulse_start, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("rel_adc", $signed(adc_data), 100);
        chk("rel_pcnt", pulse_count, 0);
        chk("rel_miss", missed_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
